snake_tile_map_builder: RTL and testbench
=========================================

// Module: snake_tile_map_builder
// PURPOSE
//  Per-frame scheduler that converts the snake segment list into a double-buffered GRID_W x GRID_H tile-occupancy bitmap.
//  Started by the VGA timing generator's screenEnd pulse. Walks the segment store one index per cycle, then swaps buffers.
//  The pixel path then needs one bitmap lookup per pixel instead of MAX_SEGS parallel compares.
//  Reports head tile, segment count, self-hit and out-of-range flags to game logic.
// PARAMETERS
//  MAX_SEGS  100  segment slots in the store
//  GRID_W    10   tile columns
//  GRID_H    10   tile rows
//  COORD_W   32   segment coordinate width; all-ones (-1) = unused slot
//  IDX_W     7    segment index width, clog2(MAX_SEGS)
// PORTS
//  clk         in   1        system clock; the single clock of this block
//  reset       in   1        asynchronous, active-low reset
//  start       in   1        build request pulse (screenEnd)
//  game_done   in   1        high: freeze; start ignored, front buffer held
//  seg_idx     out  IDX_W    segment store read index
//  seg_x       in   COORD_W  tile column of seg_idx; valid 1 cycle after seg_idx
//  seg_y       in   COORD_W  tile row of seg_idx; same timing as seg_x
//  pix_col     in   4        tile column under the current pixel
//  pix_row     in   4        tile row under the current pixel
//  occupied    out  1        front[pix_row][pix_col]; combinational
//  busy        out  1        build in progress
//  frame_done  out  1        1-cycle pulse in SWAP
//  overrun     out  1        1-cycle pulse when start arrives while busy
//  head_col    out  4        tile column of segment 0; front-buffer aligned
//  head_row    out  4        tile row of segment 0; front-buffer aligned
//  head_valid  out  1        segment 0 was valid in the last build
//  seg_count   out  IDX_W+1  valid segments found in the last build
//  self_hit    out  1        last build marked an already-set tile
//  oob         out  1        last build saw a coordinate >= GRID_W/GRID_H
// BEHAVIOUR
//  Reset (async assert): state=IDLE; both buffers zero; front select=0; seg_idx=0.
//   All other outputs 0. Release is synchronous to clk.
//  FSM: IDLE -> CLEAR -> WALK -> SWAP -> IDLE.
//  IDLE: start & !game_done -> CLEAR on next edge. start & game_done -> ignored, no overrun.
//  CLEAR: GRID_H cycles; zero one back-buffer row per cycle, rows 0..GRID_H-1. Clear per-build counters/flags.
//  WALK, issue side: seg_idx = 0,1,2,... one per cycle. Stops issuing after MAX_SEGS-1.
//  WALK, data side: data returns one cycle after issue.
//   Terminator = seg_x or seg_y all-ones. The first terminator ends WALK; later slots are never examined.
//   Valid & in range: set back[y][x]. If already set, self_hit_nxt=1. Increment count.
//   Valid & out of range: no bitmap write; oob_nxt=1; count still increments.
//   The extra index issued after the terminator is harmless; its data is discarded.
//  SWAP: 1 cycle. frame_done=1; front select toggles at the end of the cycle.
//   head_*, seg_count, self_hit and oob are updated on the same edge, so they change with the bitmap.
//  Timing: busy is high from the cycle after start.
//   N valid segments, N<MAX_SEGS: busy lasts GRID_H+N+3 cycles. Full store: GRID_H+MAX_SEGS+2 cycles.
//  start while busy: overrun pulses 1 cycle; build not restarted; request dropped.
//  game_done rising mid-build: the current build completes and swaps; subsequent starts are ignored.
//  occupied = 0 when pix_col>=GRID_W or pix_row>=GRID_H. The front buffer is never written while displayed.
//  Arithmetic: range check uses the full COORD_W unsigned compare, so -1 is never in range (it is caught as a terminator first).
//   seg_count saturates at MAX_SEGS.
// STRUCTURE
//  Shared package snake_vga_pkg:
//   GRID_W, GRID_H, TILE_SIZE=40, BOARD_X0=48, BOARD_Y0=48, COORD_INVALID='1
//   FSM state encoding (IDLE, CLEAR, WALK, SWAP)
//  Sub-module tile_bitmap_dbuf holds the two GRID_H x GRID_W bit arrays. Its ports:
//   row clear (back buffer)
//   bit set with prior-value return (back buffer)
//   combinational read (front buffer)
//   swap strobe
//  FSM, index counter and flag logic stay in this module.
// TESTING
//  1. Reset: hold reset low mid-WALK; busy=0, occupied=0 at every tile, front select=0, seg_count=0.
//  2. Basic build: segs (3,4),(2,4),(1,4), slot 3 = -1; pulse start.
//     Expect busy for 16 cycles and frame_done in the last busy cycle.
//     Expect occupied only at (1..3,4), head=(3,4), seg_count=3, self_hit=0.
//  3. Self-hit: segs (5,5),(5,6),(5,5), terminator; expect self_hit=1, seg_count=3, occupied at (5,5),(5,6) only.
//  4. Out of range: seg (10,2), seg (0,0), terminator; expect oob=1, seg_count=2, occupied only (0,0), and occupied=0 for pix_col=10.
//  5. Full store: all 100 slots valid. Expect busy for 112 cycles and seg_count=100.
//     Pulse start in WALK: expect overrun pulsed once and no restart.
//  6. Freeze: game_done=1, change segs, pulse start; busy stays 0 and the bitmap and head outputs are unchanged.

Source files
------------

// File: rtl/snake_vga_pkg.sv
// snake_vga_pkg: shared board geometry and tile-map builder state encoding.
package snake_vga_pkg;
    localparam int GRID_W    = 10;
    localparam int GRID_H    = 10;
    localparam int TILE_SIZE = 40;
    localparam int BOARD_X0  = 48;
    localparam int BOARD_Y0  = 48;
    localparam logic [31:0] COORD_INVALID = '1;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WALK, S_SWAP} state_t;
endpackage

// File: rtl/tile_bitmap_dbuf.sv
// tile_bitmap_dbuf: two GRID_H x GRID_W occupancy bitmaps; the back one is built
// while the front one is displayed, and a swap strobe exchanges them.
module tile_bitmap_dbuf #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_en,
    input  logic [3:0] clr_row,
    input  logic       set_en,
    input  logic [3:0] set_col,
    input  logic [3:0] set_row,
    output logic       set_prior,
    input  logic [3:0] rd_col,
    input  logic [3:0] rd_row,
    output logic       rd_bit,
    input  logic       swap
);
    localparam logic [3:0] GW4 = 4'(GRID_W);
    localparam logic [3:0] GH4 = 4'(GRID_H);
    logic              sel;
    logic [GRID_W-1:0] bm [2][GRID_H];
    assign set_prior = bm[!sel][set_row][set_col];
    // Off-board pixels read as empty rather than aliasing into the array
    assign rd_bit = (rd_col < GW4) && (rd_row < GH4) && bm[sel][rd_row][rd_col];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < GRID_H; r++)
                    bm[b][r] <= '0;
        end else begin
            if (swap)
                sel <= !sel;
            if (clr_en)
                bm[!sel][clr_row] <= '0;
            if (set_en)
                bm[!sel][set_row][set_col] <= 1'b1;
        end
    end
endmodule

// File: rtl/snake_tile_map_builder.sv
// snake_tile_map_builder: per-frame walk of the snake segment store into a
// double-buffered tile-occupancy bitmap, plus head/count/flag reporting.
module snake_tile_map_builder
    import snake_vga_pkg::*;
#(
    parameter int MAX_SEGS = 100,
    parameter int GRID_W   = snake_vga_pkg::GRID_W,
    parameter int GRID_H   = snake_vga_pkg::GRID_H,
    parameter int COORD_W  = 32,
    parameter int IDX_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               game_done,
    output logic [IDX_W-1:0]   seg_idx,
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    input  logic [3:0]         pix_col,
    input  logic [3:0]         pix_row,
    output logic               occupied,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun,
    output logic [3:0]         head_col,
    output logic [3:0]         head_row,
    output logic               head_valid,
    output logic [IDX_W:0]     seg_count,
    output logic               self_hit,
    output logic               oob
);
    localparam int                 CNT_W    = IDX_W + 1;
    localparam logic [COORD_W-1:0] GW_C     = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0] GH_C     = COORD_W'(GRID_H);
    localparam logic [3:0]         LAST_ROW = 4'(GRID_H - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAX_SEGS - 1);
    localparam logic [IDX_W:0]     MAX_CNT  = CNT_W'(MAX_SEGS);
    state_t         state, state_nxt;
    logic [3:0]     clr_row;
    logic           pend, iss_done, first;
    logic [IDX_W:0] cnt;
    logic           hit_b, oob_b, hv_b;
    logic [3:0]     hc_b, hr_b;
    logic           term, in_rng, take, set_en, prior, swap;
    // pend marks that seg_x/seg_y carry the data of the index issued last cycle
    assign term       = (&seg_x) || (&seg_y);
    assign in_rng     = (seg_x < GW_C) && (seg_y < GH_C);
    assign take       = (state == S_WALK) && pend && !term;
    assign set_en     = take && in_rng;
    assign swap       = state == S_SWAP;
    assign busy       = state != S_IDLE;
    assign frame_done = swap;
    assign overrun    = busy && start && !game_done;
    tile_bitmap_dbuf #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_dbuf (
        .clk       (clk),
        .reset     (reset),
        .clr_en    (state == S_CLEAR),
        .clr_row   (clr_row),
        .set_en    (set_en),
        .set_col   (seg_x[3:0]),
        .set_row   (seg_y[3:0]),
        .set_prior (prior),
        .rd_col    (pix_col),
        .rd_row    (pix_row),
        .rd_bit    (occupied),
        .swap      (swap)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = (start && !game_done) ? S_CLEAR : S_IDLE;
            S_CLEAR: state_nxt = (clr_row == LAST_ROW) ? S_WALK : S_CLEAR;
            S_WALK:  state_nxt = (pend && (term || iss_done)) ? S_SWAP : S_WALK;
            default: state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_row    <= '0;
            seg_idx    <= '0;
            pend       <= 1'b0;
            iss_done   <= 1'b0;
            first      <= 1'b0;
            cnt        <= '0;
            hit_b      <= 1'b0;
            oob_b      <= 1'b0;
            hv_b       <= 1'b0;
            hc_b       <= '0;
            hr_b       <= '0;
            seg_count  <= '0;
            self_hit   <= 1'b0;
            oob        <= 1'b0;
            head_valid <= 1'b0;
            head_col   <= '0;
            head_row   <= '0;
        end else begin
            if (state == S_CLEAR) begin
                clr_row  <= (clr_row == LAST_ROW) ? '0 : clr_row + 4'd1;
                seg_idx  <= '0;
                pend     <= 1'b0;
                iss_done <= 1'b0;
                first    <= 1'b1;
                cnt      <= '0;
                hit_b    <= 1'b0;
                oob_b    <= 1'b0;
                hv_b     <= 1'b0;
                hc_b     <= '0;
                hr_b     <= '0;
            end
            if (state == S_WALK) begin
                pend <= !iss_done;
                if (!iss_done && seg_idx == LAST_IDX)
                    iss_done <= 1'b1;
                else if (!iss_done)
                    seg_idx <= seg_idx + 1'b1;
                if (pend)
                    first <= 1'b0;
                if (take)
                    cnt <= (cnt == MAX_CNT) ? cnt : cnt + 1'b1;
                if (set_en && prior)
                    hit_b <= 1'b1;
                if (take && !in_rng)
                    oob_b <= 1'b1;
                if (take && first) begin
                    hv_b <= 1'b1;
                    hc_b <= seg_x[3:0];
                    hr_b <= seg_y[3:0];
                end
            end
            // Report registers move on the same edge as the buffer swap
            if (swap) begin
                seg_count  <= cnt;
                self_hit   <= hit_b;
                oob        <= oob_b;
                head_valid <= hv_b;
                head_col   <= hc_b;
                head_row   <= hr_b;
            end
        end
    end
endmodule

// File: tb/tb_snake_tile_map_builder.sv
// tb_snake_tile_map_builder: table-driven builds plus reset, full-store,
// overrun and freeze sequences against hand-computed expectations.
module tb_snake_tile_map_builder;
    localparam logic [31:0] NA = '1;
    typedef struct packed {
        logic [3:0][31:0] xs;
        logic [3:0][31:0] ys;
        logic [7:0]       busy_cyc;
        logic [7:0]       cnt;
        logic             hit;
        logic             ob;
        logic             hv;
        logic [3:0]       hc;
        logic [3:0]       hr;
        logic [99:0]      occ;
    } vec_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        game_done = 1'b0;
    logic [6:0]  seg_idx;
    logic [31:0] seg_x = '0;
    logic [31:0] seg_y = '0;
    logic [3:0]  pix_col = '0;
    logic [3:0]  pix_row = '0;
    logic        occupied, busy, frame_done, overrun, head_valid, self_hit, oob;
    logic [3:0]  head_col, head_row;
    logic [7:0]  seg_count;
    logic [31:0] mem_x [100];
    logic [31:0] mem_y [100];
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [6];
    snake_tile_map_builder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .game_done  (game_done),
        .seg_idx    (seg_idx),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .pix_col    (pix_col),
        .pix_row    (pix_row),
        .occupied   (occupied),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .head_col   (head_col),
        .head_row   (head_row),
        .head_valid (head_valid),
        .seg_count  (seg_count),
        .self_hit   (self_hit),
        .oob        (oob)
    );
    always #5 clk = ~clk;
    // Segment store: synchronous read, data one cycle after the index
    always @(posedge clk) begin
        seg_x <= mem_x[seg_idx];
        seg_y <= mem_y[seg_idx];
    end
    function automatic logic [99:0] t(input int c, input int r);
        logic [99:0] m;
        m = '0;
        m[r*10+c] = 1'b1;
        return m;
    endfunction
    function automatic logic [255:0] map256(input logic [99:0] o);
        logic [255:0] m;
        m = '0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                m[r*16+c] = o[r*10+c];
        return m;
    endfunction
    function automatic vec_t mk(input logic [31:0] x0, y0, x1, y1, x2, y2, x3, y3,
                                input int bc, cnt, input logic hit, ob, hv,
                                input logic [3:0] hc, hr, input logic [99:0] occ);
        vec_t v;
        v.xs = {x3, x2, x1, x0};
        v.ys = {y3, y2, y1, y0};
        v.busy_cyc = 8'(bc);
        v.cnt = 8'(cnt);
        v.hit = hit;
        v.ob = ob;
        v.hv = hv;
        v.hc = hc;
        v.hr = hr;
        v.occ = occ;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    task automatic scan(output logic [255:0] m);
        m = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                pix_row = 4'(r);
                pix_col = 4'(c);
                #1;
                m[r*16+c] = occupied;
            end
    endtask
    task automatic run_build(input int inj, input int gd_at, output int bc, output int fd_at, output int ov);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        fd_at = -1;
        ov = 0;
        while (busy && bc < 400) begin
            bc++;
            start = (bc == inj);
            if (bc == gd_at)
                game_done = 1'b1;
            #1;
            if (frame_done)
                fd_at = (fd_at == -1) ? bc : -2;
            if (overrun)
                ov++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask
    task automatic load(input vec_t v);
        for (int i = 0; i < 100; i++) begin
            mem_x[i] = (i < 4) ? v.xs[i] : NA;
            mem_y[i] = (i < 4) ? v.ys[i] : NA;
        end
    endtask
    task automatic check_result(input string tag, input vec_t v);
        logic [255:0] m;
        chk({tag, " seg_count"}, seg_count, v.cnt);
        chk({tag, " self_hit"}, self_hit, v.hit);
        chk({tag, " oob"}, oob, v.ob);
        chk({tag, " head_valid"}, head_valid, v.hv);
        if (v.hv) begin
            chk({tag, " head_col"}, head_col, v.hc);
            chk({tag, " head_row"}, head_row, v.hr);
        end
        scan(m);
        chk({tag, " bitmap"}, m, map256(v.occ));
    endtask
    task automatic run_vec(input string tag, input vec_t v);
        int bc, fd, ov;
        load(v);
        run_build(0, 0, bc, fd, ov);
        chk({tag, " busy_cycles"}, bc, v.busy_cyc);
        chk({tag, " frame_done_cycle"}, fd, v.busy_cyc);
        chk({tag, " overrun"}, ov, 0);
        check_result(tag, v);
    endtask
    initial begin
        logic [255:0] m;
        vec_t full;
        int bc, fd, ov;
        vecs[0] = mk(3, 4, 2, 4, 1, 4, NA, NA, 16, 3, 0, 0, 1, 3, 4, t(3, 4) | t(2, 4) | t(1, 4));
        vecs[1] = mk(5, 5, 5, 6, 5, 5, NA, NA, 16, 3, 1, 0, 1, 5, 5, t(5, 5) | t(5, 6));
        vecs[2] = mk(10, 2, 0, 0, NA, NA, NA, NA, 15, 2, 0, 1, 1, 10, 2, t(0, 0));
        vecs[3] = mk(7, 9, 2, NA, 4, 4, NA, NA, 14, 1, 0, 0, 1, 7, 9, t(7, 9));
        vecs[4] = mk(9, 9, 32'h8000_0003, 1, NA, NA, NA, NA, 15, 2, 0, 1, 1, 9, 9, t(9, 9));
        vecs[5] = mk(NA, NA, 1, 1, NA, NA, NA, NA, 13, 0, 0, 0, 0, 0, 0, '0);
        load(vecs[0]);
        repeat (3) @(negedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst seg_idx", seg_idx, 0);
        chk("rst seg_count", seg_count, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst occupied", occupied, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++)
            run_vec($sformatf("v%0d", k), vecs[k]);
        // Reset asserted in the middle of WALK
        load(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst seg_count", seg_count, 0);
        chk("midrst seg_idx", seg_idx, 0);
        chk("midrst head_valid", head_valid, 0);
        scan(m);
        chk("midrst bitmap", m, '0);
        @(negedge clk);
        reset = 1'b1;
        run_vec("post_rst", vecs[0]);
        // Full store with a start request dropped mid-WALK
        for (int i = 0; i < 100; i++) begin
            mem_x[i] = i % 10;
            mem_y[i] = i / 10;
        end
        run_build(40, 0, bc, fd, ov);
        chk("full busy_cycles", bc, 112);
        chk("full frame_done_cycle", fd, 112);
        chk("full overrun_pulses", ov, 1);
        repeat (2) @(negedge clk);
        chk("full no_restart", busy, 0);
        full = mk(0, 0, 1, 0, 2, 0, 3, 0, 112, 100, 0, 0, 1, 0, 0, {100{1'b1}});
        check_result("full", full);
        // game_done rises mid-build: build still completes
        load(vecs[0]);
        run_build(0, 14, bc, fd, ov);
        chk("gd_mid busy_cycles", bc, 16);
        check_result("gd_mid", vecs[0]);
        // Frozen: start ignored, front buffer and head held
        load(vecs[1]);
        run_build(0, 0, bc, fd, ov);
        chk("freeze busy_cycles", bc, 0);
        chk("freeze overrun", ov, 0);
        check_result("freeze", vecs[0]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
